// File: rtl/ami_app_addr_xlat_pkg.sv
// Shared AMI types for the per-app address-translation stage: request/response
// structs, TLB entry layout, TLB state encoding and sizing constants.
package ami_app_addr_xlat_pkg;

    localparam int AMI_ADDR_WIDTH          = 64;
    localparam int AMI_DATA_WIDTH          = 64;
    localparam int AMI_SIZE_WIDTH          = 6;
    localparam int AMI_APP_BITS            = 2;
    localparam int AMI_PORT_BITS           = 1;
    localparam int AMI_CHANNEL_BITS        = 1;
    localparam int AMI_NUM_APP_TLB_ENTRIES = 4;
    localparam int ADDR_XLATED_Q_DEPTH     = 4;
    localparam bit DISABLE_INTERLEAVE      = 1'b0;
    // Channels interleave on 64-byte lines.
    localparam int INTERLEAVE_LSB          = 6;

    typedef enum logic [1:0] {
        DISABLED    = 2'd0,
        PROGRAMMING = 2'd1,
        ENABLED     = 2'd2
    } APP_TLB_STATE;

    typedef struct packed {
        logic                      valid;
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                        valid;
        logic                        isWrite;
        logic [AMI_APP_BITS-1:0]     srcApp;
        logic [AMI_PORT_BITS-1:0]    srcPort;
        logic [AMI_CHANNEL_BITS-1:0] channel;
        logic [AMI_ADDR_WIDTH-1:0]   addr;
        logic [AMI_DATA_WIDTH-1:0]   data;
        logic [AMI_SIZE_WIDTH-1:0]   size;
    } AMIReq;

    typedef struct packed {
        logic                      valid;
        logic                      in_memory;
        logic                      readable;
        logic                      writable;
        logic [AMI_ADDR_WIDTH-1:0] va_start;
        logic [AMI_ADDR_WIDTH-1:0] va_end;
        logic [AMI_ADDR_WIDTH-1:0] pa;
    } AMIAPP_TLB_Entry;

    typedef struct packed {
        logic                      valid;
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
    } AMIXlatFault;

endpackage

// File: rtl/ami_xlat_fifo.sv
// Generic AMIReq FIFO with simultaneous push/pop; head.valid reflects non-empty.
module ami_xlat_fifo
    import ami_app_addr_xlat_pkg::*;
#(
    parameter int DEPTH = ADDR_XLATED_Q_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  AMIReq            push_data_i,
    input  logic             pop_i,
    output AMIReq            head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    AMIReq            mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q gates head validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    always_comb begin
        head_o       = mem_q[rd_ptr_q];
        head_o.valid = (count_q != '0);
    end

endmodule

// File: rtl/ami_app_addr_xlat.sv
// Per-app/per-port VA->PA translation with a small TLB, permission check and output queue.
// Optional AMI_XLAT_STATS_EN adds saturating hit_count/fault_count outputs.
module ami_app_addr_xlat
    import ami_app_addr_xlat_pkg::*;
#(
    parameter logic [AMI_APP_BITS-1:0]  APP_ID      = '0,
    parameter logic [AMI_PORT_BITS-1:0] PORT_ID     = '0,
    parameter int                       NUM_ENTRIES = AMI_NUM_APP_TLB_ENTRIES,
    parameter int                       OUT_Q_DEPTH = ADDR_XLATED_Q_DEPTH,
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  AMIRequest                 req_in,
    output logic                      req_in_grant,
    output AMIReq                     req_out,
    input  logic                      req_out_grant,
    input  logic                      prog_start,
    input  logic                      prog_wr,
    input  logic [IDX_W-1:0]          prog_idx,
    input  AMIAPP_TLB_Entry           prog_entry,
    input  logic                      prog_done,
    output logic [1:0]                state_out,
    output logic                      fault_valid,
    output logic [AMI_ADDR_WIDTH-1:0] fault_addr,
    output logic                      fault_is_write
`ifdef AMI_XLAT_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               fault_count
`endif
);

    localparam int CNT_W = $clog2(OUT_Q_DEPTH + 1);

    APP_TLB_STATE              state_q;
    AMIAPP_TLB_Entry           tlb_q [NUM_ENTRIES];
    logic                      s1_valid_q;
    AMIReq                     s1_req_q, s1_d;
    AMIXlatFault               fault_q;
    logic                      hit;
    logic [AMI_ADDR_WIDTH-1:0] xlat_pa;
    logic [CNT_W-1:0]          q_count;
    logic                      room;

    // Space is reserved for the request already in stage 1, so a push never meets a full queue.
    assign room = (32'(q_count) + 32'(s1_valid_q)) < OUT_Q_DEPTH;
    assign req_in_grant = req_in.valid && (state_q == ENABLED) && !prog_start && room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISABLED;
        end else begin
            case (state_q)
                DISABLED:    if (prog_start) state_q <= PROGRAMMING;
                PROGRAMMING: if (prog_done) state_q <= ENABLED;
                ENABLED:     if (prog_start && !s1_valid_q) state_q <= PROGRAMMING;
                default:     state_q <= DISABLED;
            endcase
        end
    end

    assign state_out = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                tlb_q[i] <= '0;
        end else if (state_q == PROGRAMMING && prog_wr && 32'(prog_idx) < NUM_ENTRIES) begin
            tlb_q[prog_idx] <= prog_entry;
        end
    end

    // Lowest matching index wins; the lookup result is captured into stage 1.
    always_comb begin
        hit     = 1'b0;
        xlat_pa = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && tlb_q[i].valid && tlb_q[i].in_memory &&
                req_in.addr >= tlb_q[i].va_start && req_in.addr <= tlb_q[i].va_end &&
                (req_in.isWrite ? tlb_q[i].writable : tlb_q[i].readable)) begin
                hit     = 1'b1;
                xlat_pa = tlb_q[i].pa + (req_in.addr - tlb_q[i].va_start);
            end
        end
        s1_d         = '0;
        s1_d.valid   = 1'b1;
        s1_d.isWrite = req_in.isWrite;
        s1_d.srcApp  = APP_ID;
        s1_d.srcPort = PORT_ID;
        s1_d.channel = DISABLE_INTERLEAVE ? '0 : xlat_pa[INTERLEAVE_LSB +: AMI_CHANNEL_BITS];
        s1_d.addr    = xlat_pa;
        s1_d.data    = req_in.data;
        s1_d.size    = req_in.size;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            fault_q    <= '0;
        end else begin
            s1_valid_q    <= req_in_grant && hit;
            fault_q.valid <= req_in_grant && !hit;
            if (req_in_grant && hit)
                s1_req_q <= s1_d;
            if (req_in_grant && !hit) begin
                fault_q.addr    <= req_in.addr;
                fault_q.isWrite <= req_in.isWrite;
            end
        end
    end

    assign fault_valid    = fault_q.valid;
    assign fault_addr     = fault_q.addr;
    assign fault_is_write = fault_q.isWrite;

    ami_xlat_fifo #(
        .DEPTH (OUT_Q_DEPTH)
    ) u_out_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s1_valid_q),
        .push_data_i (s1_req_q),
        .pop_i       (req_out_grant),
        .head_o      (req_out),
        .count_o     (q_count)
    );

`ifdef AMI_XLAT_STATS_EN
    logic [31:0] hit_count_q, fault_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q   <= '0;
            fault_count_q <= '0;
        end else begin
            if (s1_valid_q && hit_count_q != '1)
                hit_count_q <= hit_count_q + 1'b1;
            if (fault_q.valid && fault_count_q != '1)
                fault_count_q <= fault_count_q + 1'b1;
        end
    end

    assign hit_count   = hit_count_q;
    assign fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_ami_app_addr_xlat.sv
// Self-checking bench for ami_app_addr_xlat: directed scenarios plus a scoreboard on req_out.
`timescale 1ns/1ps
module tb_ami_app_addr_xlat;
    import ami_app_addr_xlat_pkg::*;

    localparam logic [AMI_APP_BITS-1:0]  APP_ID  = 2'd2;
    localparam logic [AMI_PORT_BITS-1:0] PORT_ID = 1'b1;
    localparam int DEPTH = ADDR_XLATED_Q_DEPTH;
    localparam int IDX_W = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    AMIRequest       req_in;
    logic            req_in_grant;
    AMIReq           req_out;
    logic            req_out_grant;
    logic            prog_start, prog_wr, prog_done;
    logic [IDX_W-1:0] prog_idx;
    AMIAPP_TLB_Entry prog_entry;
    logic [1:0]      state_out;
    logic            fault_valid;
    logic [63:0]     fault_addr;
    logic            fault_is_write;
`ifdef AMI_XLAT_STATS_EN
    logic [31:0]     hit_count, fault_count;
`endif

    int checks = 0;
    int errors = 0;
    AMIReq exp_q[$];

    always #5 clk = ~clk;

    ami_app_addr_xlat #(
        .APP_ID      (APP_ID),
        .PORT_ID     (PORT_ID),
        .NUM_ENTRIES (4),
        .OUT_Q_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_in         (req_in),
        .req_in_grant   (req_in_grant),
        .req_out        (req_out),
        .req_out_grant  (req_out_grant),
        .prog_start     (prog_start),
        .prog_wr        (prog_wr),
        .prog_idx       (prog_idx),
        .prog_entry     (prog_entry),
        .prog_done      (prog_done),
        .state_out      (state_out),
        .fault_valid    (fault_valid),
        .fault_addr     (fault_addr),
        .fault_is_write (fault_is_write)
`ifdef AMI_XLAT_STATS_EN
        ,
        .hit_count      (hit_count),
        .fault_count    (fault_count)
`endif
    );

    // Scoreboard: compare every popped head against the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (rst_n && req_out.valid && req_out_grant) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, expected queue empty", req_out);
            end else begin
                AMIReq e;
                e = exp_q.pop_front();
                if (req_out !== e) begin
                    errors++;
                    $display("FAIL sb_req_out: got %h, expected %h", req_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic AMIAPP_TLB_Entry mk_entry(input logic [63:0] vs, input logic [63:0] ve,
                                                 input logic [63:0] pa, input logic rd,
                                                 input logic wr, input logic inmem);
        AMIAPP_TLB_Entry e;
        e.valid = 1'b1; e.in_memory = inmem; e.readable = rd; e.writable = wr;
        e.va_start = vs; e.va_end = ve; e.pa = pa;
        return e;
    endfunction

    function automatic AMIReq mk_exp(input AMIRequest r, input logic [63:0] pa);
        AMIReq e;
        e.valid = 1'b1; e.isWrite = r.isWrite; e.srcApp = APP_ID; e.srcPort = PORT_ID;
        e.channel = DISABLE_INTERLEAVE ? '0 : pa[INTERLEAVE_LSB +: AMI_CHANNEL_BITS];
        e.addr = pa; e.data = r.data; e.size = r.size;
        return e;
    endfunction

    task automatic drive_req(input logic wr, input logic [63:0] addr);
        req_in.valid   = 1'b1;
        req_in.isWrite = wr;
        req_in.addr    = addr;
        req_in.data    = {$urandom, $urandom};
        req_in.size    = 6'($urandom_range(1, 63));
    endtask

    task automatic prog_write(input int idx, input AMIAPP_TLB_Entry e, input logic done);
        prog_wr = 1'b1; prog_idx = IDX_W'(idx); prog_entry = e; prog_done = done;
        @(negedge clk);
        prog_wr = 1'b0; prog_done = 1'b0;
    endtask

    task automatic drain(input string name);
        req_out_grant = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (req_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_extra: req_out.valid=%b after drain, expected 0", name, req_out.valid);
        end
        req_out_grant = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '0; req_out_grant = 1'b0;
        prog_start = 1'b0; prog_wr = 1'b0; prog_done = 1'b0; prog_idx = '0; prog_entry = '0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_out); end
        if (req_out.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", req_out.valid); end
        if (req_in_grant !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", req_in_grant); end
        if (fault_valid !== 1'b0) begin errors++; $display("FAIL rst_fault_valid: got %b expected 0", fault_valid); end
        if (fault_addr !== 64'h0) begin errors++; $display("FAIL rst_fault_addr: got %h expected 0", fault_addr); end
        if (fault_is_write !== 1'b0) begin errors++; $display("FAIL rst_fault_wr: got %b expected 0", fault_is_write); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_disabled();
        drive_req(1'b0, 64'h1040);
        #1;
        checks++;
        if (req_in_grant !== 1'b0) begin errors++; $display("FAIL dis_grant: got %b expected 0", req_in_grant); end
        prog_write(3, mk_entry(64'h9000, 64'h9FFF, 64'h5000_0000, 1'b1, 1'b1, 1'b1), 1'b0);
        req_in = '0;
        checks++;
        if (state_out !== 2'd0) begin errors++; $display("FAIL dis_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_program();
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL prog_state: got %0d expected 1", state_out); end
        drive_req(1'b0, 64'h1040);
        #1;
        checks++;
        if (req_in_grant !== 1'b0) begin errors++; $display("FAIL prog_grant: got %b expected 0", req_in_grant); end
        req_in = '0;
        prog_write(0, mk_entry(64'h1000, 64'h1FFF, 64'h8000_0000, 1'b1, 1'b1, 1'b1), 1'b0);
        prog_write(2, mk_entry(64'h3000, 64'h3FFF, 64'h6000_0000, 1'b1, 1'b1, 1'b0), 1'b0);
        prog_write(1, mk_entry(64'h1800, 64'h27FF, 64'h4000_0000, 1'b1, 1'b1, 1'b1), 1'b1);
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL prog_enable: got %0d expected 2", state_out); end
    endtask

    task automatic test_latency();
        drive_req(1'b0, 64'h1040);
        #1;
        checks++;
        if (req_in_grant !== 1'b1) begin errors++; $display("FAIL lat_grant: got %b expected 1", req_in_grant); end
        exp_q.push_back(mk_exp(req_in, 64'h8000_0040));
        @(negedge clk);
        req_in = '0;
        checks += 2;
        if (req_out.valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid: got %b expected 0", req_out.valid); end
        if (fault_valid !== 1'b0) begin errors++; $display("FAIL lat_fault: got %b expected 0", fault_valid); end
        @(negedge clk);
        checks += 4;
        if (req_out.valid !== 1'b1) begin errors++; $display("FAIL lat_n2_valid: got %b expected 1", req_out.valid); end
        if (req_out.addr !== 64'h8000_0040) begin errors++; $display("FAIL lat_pa: got %h expected 80000040", req_out.addr); end
        if (req_out.channel !== 1'b1) begin errors++; $display("FAIL lat_channel: got %0d expected 1", req_out.channel); end
        if (req_out.srcApp !== APP_ID) begin errors++; $display("FAIL lat_src_app: got %0d expected %0d", req_out.srcApp, APP_ID); end
        drain("lat");
    endtask

    task automatic test_translate();
        logic [63:0] va_t [5] = '{64'h1000, 64'h1FFF, 64'h1800, 64'h2040, 64'h27FF};
        logic [63:0] pa_t [5] = '{64'h8000_0000, 64'h8000_0FFF, 64'h8000_0800, 64'h4000_0840, 64'h4000_0FFF};
        logic        wr_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        req_out_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(wr_t[i], va_t[i]);
            #1;
            checks++;
            if (req_in_grant !== 1'b1) begin errors++; $display("FAIL xlat_grant[%0d]: got %b expected 1", i, req_in_grant); end
            else exp_q.push_back(mk_exp(req_in, pa_t[i]));
            @(negedge clk);
        end
        req_in = '0;
        drain("xlat");
    endtask

    task automatic test_fault();
        logic [63:0] va_t [4] = '{64'h9040, 64'h2800, 64'h3040, 64'h0FFF};
        logic        wr_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_req(wr_t[i], va_t[i]);
            #1;
            checks++;
            if (req_in_grant !== 1'b1) begin errors++; $display("FAIL flt_grant[%0d]: got %b expected 1", i, req_in_grant); end
            @(negedge clk);
            req_in = '0;
            checks += 3;
            if (fault_valid !== 1'b1) begin errors++; $display("FAIL flt_pulse[%0d]: got %b expected 1", i, fault_valid); end
            if (fault_addr !== va_t[i]) begin errors++; $display("FAIL flt_addr[%0d]: got %h expected %h", i, fault_addr, va_t[i]); end
            if (fault_is_write !== wr_t[i]) begin errors++; $display("FAIL flt_wr[%0d]: got %b expected %b", i, fault_is_write, wr_t[i]); end
            @(negedge clk);
            checks += 3;
            if (fault_valid !== 1'b0) begin errors++; $display("FAIL flt_end[%0d]: got %b expected 0", i, fault_valid); end
            if (fault_addr !== va_t[i]) begin errors++; $display("FAIL flt_hold[%0d]: got %h expected %h", i, fault_addr, va_t[i]); end
            if (req_out.valid !== 1'b0) begin errors++; $display("FAIL flt_fwd[%0d]: got %b expected 0", i, req_out.valid); end
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        logic [63:0] off;
        req_out_grant = 1'b0;
        off = 64'($urandom_range(0, 32'hFFF));
        drive_req(1'($urandom_range(0, 1)), 64'h1000 + off);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_in_grant === 1'b1) begin
                accepted++;
                exp_q.push_back(mk_exp(req_in, 64'h8000_0000 + off));
                @(negedge clk);
                off = 64'($urandom_range(0, 32'hFFF));
                drive_req(1'($urandom_range(0, 1)), 64'h1000 + off);
            end else begin
                @(negedge clk);
            end
        end
        #1;
        checks += 2;
        if (accepted != DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH); end
        if (req_in_grant !== 1'b0) begin errors++; $display("FAIL bp_grant_full: got %b expected 0", req_in_grant); end
        @(negedge clk);
        req_in = '0;
        drain("bp");
    endtask

    task automatic test_reprogram();
        drive_req(1'b0, 64'h1080);
        #1;
        checks++;
        if (req_in_grant !== 1'b1) begin errors++; $display("FAIL rp_first_grant: got %b expected 1", req_in_grant); end
        exp_q.push_back(mk_exp(req_in, 64'h8000_0080));
        @(negedge clk);
        drive_req(1'b0, 64'h1040);
        prog_start = 1'b1;
        #1;
        checks++;
        if (req_in_grant !== 1'b0) begin errors++; $display("FAIL rp_grant_blocked: got %b expected 0", req_in_grant); end
        @(negedge clk);
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL rp_wait_s1: got %0d expected 2", state_out); end
        @(negedge clk);
        prog_start = 1'b0;
        req_in = '0;
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL rp_state: got %0d expected 1", state_out); end
        drain("rp_q");
        prog_write(0, mk_entry(64'h1000, 64'h1FFF, 64'h8000_0000, 1'b1, 1'b0, 1'b1), 1'b1);
        drive_req(1'b1, 64'h1040);
        #1;
        checks++;
        if (req_in_grant !== 1'b1) begin errors++; $display("FAIL rp_wr_grant: got %b expected 1", req_in_grant); end
        @(negedge clk);
        req_in = '0;
        checks += 3;
        if (fault_valid !== 1'b1) begin errors++; $display("FAIL rp_wr_fault: got %b expected 1", fault_valid); end
        if (fault_addr !== 64'h1040) begin errors++; $display("FAIL rp_wr_addr: got %h expected 1040", fault_addr); end
        if (fault_is_write !== 1'b1) begin errors++; $display("FAIL rp_wr_type: got %b expected 1", fault_is_write); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_out.valid !== 1'b0) begin errors++; $display("FAIL rp_wr_fwd: got %b expected 0", req_out.valid); end
        end
        drive_req(1'b0, 64'h1040);
        #1;
        checks++;
        if (req_in_grant !== 1'b1) begin errors++; $display("FAIL rp_rd_grant: got %b expected 1", req_in_grant); end
        exp_q.push_back(mk_exp(req_in, 64'h8000_0040));
        @(negedge clk);
        req_in = '0;
        drain("rp_rd");
    endtask

    task automatic test_reset_midstream();
        req_out_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, 64'h1100 + 64'(i * 64));
            #1;
            checks++;
            if (req_in_grant !== 1'b1) begin errors++; $display("FAIL mr_grant[%0d]: got %b expected 1", i, req_in_grant); end
            exp_q.push_back(mk_exp(req_in, 64'h8000_0100 + 64'(i * 64)));
            @(negedge clk);
        end
        req_in = '0;
        @(negedge clk);
        checks++;
        if (req_out.valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid: got %b expected 1", req_out.valid); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks += 2;
        if (req_out.valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", req_out.valid); end
        if (state_out !== 2'd0) begin errors++; $display("FAIL mr_state: got %0d expected 0", state_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        prog_done = 1'b1;
        @(negedge clk);
        prog_done = 1'b0;
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL mr_reenable: got %0d expected 2", state_out); end
        for (int i = 0; i < 2; i++) begin
            logic [63:0] va;
            va = (i == 0) ? 64'h1040 : 64'h2040;
            drive_req(1'b0, va);
            #1;
            checks++;
            if (req_in_grant !== 1'b1) begin errors++; $display("FAIL mr_post_grant[%0d]: got %b expected 1", i, req_in_grant); end
            @(negedge clk);
            req_in = '0;
            checks += 2;
            if (fault_valid !== 1'b1) begin errors++; $display("FAIL mr_entry_invalid[%0d]: got %b expected 1", i, fault_valid); end
            if (fault_addr !== va) begin errors++; $display("FAIL mr_fault_addr[%0d]: got %h expected %h", i, fault_addr, va); end
            @(negedge clk);
        end
        checks++;
        if (req_out.valid !== 1'b0) begin errors++; $display("FAIL mr_fwd: got %b expected 0", req_out.valid); end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_program();
        test_latency();
        test_translate();
        test_fault();
        test_backpressure();
        test_reprogram();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
